// File: rtl/qgemm_sram_port_scheduler.sv
// qgemm_sram_port_scheduler
// Schedules read and write bursts from the GEMM engine onto one shared SRAM
// port. An AXI-side agent may own the port on any cycle (port_busy). In that
// case no SRAM access is issued. Read data returns one cycle after issue and
// is staged in a 2-entry FIFO. Issue is throttled so the FIFO can never
// overflow.
//
// Build option: define QGEMM_SCHED_RR_EN to resolve simultaneous read/write
// requests round-robin, alternating from the last granted type. Without it,
// read always wins a tie.
module qgemm_sram_port_scheduler #(
    parameter int BW_INDEX = 8,
    parameter int WIDTH    = 512,
    parameter int BW_LEN   = 8
) (
    input  logic                  clk,
    input  logic                  rstnn,
    // read request
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [BW_INDEX-1:0]   rd_req_index,
    input  logic [BW_LEN-1:0]     rd_req_len,
    // read data
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_data_last,
    output logic                  rd_data_valid,
    input  logic                  rd_data_ready,
    // write request
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [BW_INDEX-1:0]   wr_req_index,
    input  logic [BW_LEN-1:0]     wr_req_len,
    // write data
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH/8-1:0]    wr_be,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    output logic                  wr_done,
    // SRAM port
    input  logic                  port_busy,
    output logic                  mem_renable,
    output logic                  mem_wenable,
    output logic [BW_INDEX-1:0]   mem_index,
    output logic [WIDTH/8-1:0]    mem_byte_enable,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int BW_BE = WIDTH / 8;
    localparam logic [BW_INDEX-1:0] ROW_STEP = {{(BW_INDEX-1){1'b0}}, 1'b1};
    localparam logic [BW_LEN-1:0]   BEAT_STEP = {{(BW_LEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                state_q;
    logic                  run_q;          // high from the first edge after reset release
    logic [BW_INDEX-1:0]   row_q;
    logic [BW_LEN-1:0]     len_q;
    logic [BW_LEN-1:0]     beat_q;
`ifdef QGEMM_SCHED_RR_EN
    logic                  last_grant_wr_q; // 1: last grant went to write
`endif

    // one read may be in flight at the SRAM; its last-beat tag travels with it
    logic                  inflight_q;
    logic                  inflight_last_q;

    // 2-entry read return FIFO
    logic [WIDTH-1:0]      fifo_data_q [2];
    logic [1:0]            fifo_last_q;
    logic                  fifo_wptr_q;
    logic                  fifo_rptr_q;
    logic [1:0]            fifo_count_q;

    logic                  grant_rd_s;
    logic                  grant_wr_s;
    logic                  beat_last_s;
    logic                  rd_space_s;
    logic                  rd_issue_s;
    logic                  wr_ready_s;
    logic                  wr_issue_s;
    logic                  fifo_valid_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;

    // Arbitrate between requesters while idle; nothing is granted in the first cycle after reset
    always_comb begin
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
        if ((state_q == ST_IDLE) && run_q) begin
            if (rd_req_valid && wr_req_valid) begin
`ifdef QGEMM_SCHED_RR_EN
                if (last_grant_wr_q) begin
                    grant_rd_s = 1'b1;
                end else begin
                    grant_wr_s = 1'b1;
                end
`else
                grant_rd_s = 1'b1;
`endif
            end else if (rd_req_valid) begin
                grant_rd_s = 1'b1;
            end else if (wr_req_valid) begin
                grant_wr_s = 1'b1;
            end else begin
                grant_rd_s = 1'b0;
                grant_wr_s = 1'b0;
            end
        end else begin
            grant_rd_s = 1'b0;
            grant_wr_s = 1'b0;
        end
    end

    // Issue qualification: reads need a free FIFO slot counting the one in flight
    always_comb begin
        beat_last_s = (beat_q == len_q);
        rd_space_s  = (({1'b0, fifo_count_q} + {2'b00, inflight_q}) < 3'd2);
        rd_issue_s  = (state_q == ST_READ) && !port_busy && rd_space_s;
        wr_ready_s  = (state_q == ST_WRITE) && !port_busy;
        wr_issue_s  = wr_ready_s && wr_data_valid;
    end

    // Burst control FSM: latch the granted request, step row/beat on every issue
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q         <= ST_IDLE;
            run_q           <= 1'b0;
            row_q           <= {BW_INDEX{1'b0}};
            len_q           <= {BW_LEN{1'b0}};
            beat_q          <= {BW_LEN{1'b0}};
`ifdef QGEMM_SCHED_RR_EN
            last_grant_wr_q <= 1'b1;
`endif
        end else begin
            run_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (grant_rd_s) begin
                        state_q         <= ST_READ;
                        row_q           <= rd_req_index;
                        len_q           <= rd_req_len;
                        beat_q          <= {BW_LEN{1'b0}};
`ifdef QGEMM_SCHED_RR_EN
                        last_grant_wr_q <= 1'b0;
`endif
                    end else if (grant_wr_s) begin
                        state_q         <= ST_WRITE;
                        row_q           <= wr_req_index;
                        len_q           <= wr_req_len;
                        beat_q          <= {BW_LEN{1'b0}};
`ifdef QGEMM_SCHED_RR_EN
                        last_grant_wr_q <= 1'b1;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (rd_issue_s) begin
                        row_q  <= row_q + ROW_STEP;
                        beat_q <= beat_q + BEAT_STEP;
                        if (beat_last_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end else begin
                        state_q <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (wr_issue_s) begin
                        row_q  <= row_q + ROW_STEP;
                        beat_q <= beat_q + BEAT_STEP;
                        if (beat_last_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end else begin
                        state_q <= ST_WRITE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Remember whether a read was issued last cycle and whether it was the burst's last beat
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rd_issue_s;
            inflight_last_q <= rd_issue_s && beat_last_s;
        end
    end

    // Returning data is only accepted for a read this block actually issued
    always_comb begin
        fifo_valid_s = (fifo_count_q != 2'd0);
        fifo_pop_s   = fifo_valid_s && rd_data_ready;
        fifo_push_s  = mem_rvalid && inflight_q && ((fifo_count_q != 2'd2) || fifo_pop_s);
    end

    // Read return FIFO: simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            fifo_data_q[0] <= {WIDTH{1'b0}};
            fifo_data_q[1] <= {WIDTH{1'b0}};
            fifo_last_q    <= 2'b00;
            fifo_wptr_q    <= 1'b0;
            fifo_rptr_q    <= 1'b0;
            fifo_count_q   <= 2'd0;
        end else begin
            if (fifo_push_s) begin
                fifo_data_q[fifo_wptr_q] <= mem_rdata;
                fifo_last_q[fifo_wptr_q] <= inflight_last_q;
                fifo_wptr_q              <= ~fifo_wptr_q;
            end else begin
                fifo_wptr_q <= fifo_wptr_q;
            end
            if (fifo_pop_s) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end else begin
                fifo_rptr_q <= fifo_rptr_q;
            end
            case ({fifo_push_s, fifo_pop_s})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // Drive the port and handshake outputs; everything is zero when nothing is happening
    always_comb begin
        rd_req_ready    = grant_rd_s;
        wr_req_ready    = grant_wr_s;
        wr_data_ready   = wr_ready_s;
        wr_done         = wr_issue_s && beat_last_s;
        mem_renable     = rd_issue_s;
        mem_wenable     = wr_issue_s;
        mem_index       = {BW_INDEX{1'b0}};
        mem_wdata       = {WIDTH{1'b0}};
        mem_byte_enable = {BW_BE{1'b0}};
        rd_data_valid   = fifo_valid_s;
        rd_data         = {WIDTH{1'b0}};
        rd_data_last    = 1'b0;
        if (rd_issue_s || wr_issue_s) begin
            mem_index = row_q;
        end else begin
            mem_index = {BW_INDEX{1'b0}};
        end
        if (wr_issue_s) begin
            mem_wdata       = wr_data;
            mem_byte_enable = wr_be;
        end else begin
            mem_wdata       = {WIDTH{1'b0}};
            mem_byte_enable = {BW_BE{1'b0}};
        end
        if (fifo_valid_s) begin
            rd_data      = fifo_data_q[fifo_rptr_q];
            rd_data_last = fifo_last_q[fifo_rptr_q];
        end else begin
            rd_data      = {WIDTH{1'b0}};
            rd_data_last = 1'b0;
        end
    end

endmodule

// File: tb/tb_qgemm_sram_port_scheduler.sv
// Directed bench for qgemm_sram_port_scheduler with a one-cycle-latency SRAM model.
`timescale 1ns/1ps
module tb_qgemm_sram_port_scheduler;

    localparam int BW_INDEX = 8;
    localparam int WIDTH    = 512;
    localparam int BW_LEN   = 8;
    localparam int BW_BE    = WIDTH / 8;

    logic                clk = 1'b0;
    logic                rstnn;
    logic                rd_req_valid, rd_req_ready;
    logic [BW_INDEX-1:0] rd_req_index;
    logic [BW_LEN-1:0]   rd_req_len;
    logic [WIDTH-1:0]    rd_data;
    logic                rd_data_last, rd_data_valid, rd_data_ready;
    logic                wr_req_valid, wr_req_ready;
    logic [BW_INDEX-1:0] wr_req_index;
    logic [BW_LEN-1:0]   wr_req_len;
    logic [WIDTH-1:0]    wr_data;
    logic [BW_BE-1:0]    wr_be;
    logic                wr_data_valid, wr_data_ready, wr_done;
    logic                port_busy, mem_renable, mem_wenable;
    logic [BW_INDEX-1:0] mem_index;
    logic [BW_BE-1:0]    mem_byte_enable;
    logic [WIDTH-1:0]    mem_wdata, mem_rdata;
    logic                mem_rvalid;

    always #5 clk = ~clk;

    qgemm_sram_port_scheduler #(.BW_INDEX(BW_INDEX), .WIDTH(WIDTH), .BW_LEN(BW_LEN)) dut (
        .clk(clk), .rstnn(rstnn),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_index(rd_req_index), .rd_req_len(rd_req_len),
        .rd_data(rd_data), .rd_data_last(rd_data_last),
        .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_index(wr_req_index), .wr_req_len(wr_req_len),
        .wr_data(wr_data), .wr_be(wr_be), .wr_data_valid(wr_data_valid),
        .wr_data_ready(wr_data_ready), .wr_done(wr_done),
        .port_busy(port_busy), .mem_renable(mem_renable), .mem_wenable(mem_wenable),
        .mem_index(mem_index), .mem_byte_enable(mem_byte_enable),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [WIDTH-1:0] pat(input logic [7:0] r);
        pat = {16{8'hA5, r, ~r, 8'h3C}};
    endfunction

    function automatic logic [WIDTH-1:0] wdat(input logic [7:0] k);
        wdat = {16{8'hD0, k, 8'h0D, ~k}};
    endfunction

    // SRAM model: one-cycle read latency, byte-enabled writes, preloaded with pat(row)
    logic [WIDTH-1:0] tb_mem [256];
    bit               mem_init = 1'b0;
    always @(posedge clk) begin
        logic [WIDTH-1:0] tmp;
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] = pat(8'(i));
            mem_init = 1'b1;
        end
        mem_rvalid <= mem_renable;
        mem_rdata  <= tb_mem[mem_index];
        if (mem_wenable) begin
            tmp = tb_mem[mem_index];
            for (int b = 0; b < BW_BE; b++)
                if (mem_byte_enable[b]) tmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
            tb_mem[mem_index] = tmp;
        end
    end

    // Event log sampled on the falling edge
    logic [7:0]       rd_rows[$];
    logic [7:0]       wr_rows[$];
    logic [WIDTH-1:0] wr_datas[$];
    logic [BW_BE-1:0] wr_bes[$];
    logic [WIDTH-1:0] beat_data[$];
    logic             beat_last[$];
    bit               grant_q[$];   // 0 = read grant, 1 = write grant
    int               wr_done_cnt = 0;
    int               wr_done_at = 0;
    int               viol = 0;
    bit               hold_q = 1'b0;
    logic [WIDTH-1:0] hold_data;

    always @(negedge clk) begin
        if (rstnn === 1'b1) begin
            if (mem_renable) rd_rows.push_back(mem_index);
            if (mem_wenable) begin
                wr_rows.push_back(mem_index);
                wr_datas.push_back(mem_wdata);
                wr_bes.push_back(mem_byte_enable);
            end
            if (wr_done) begin
                wr_done_cnt++;
                wr_done_at = wr_rows.size();
            end
            if (rd_data_valid && rd_data_ready) begin
                beat_data.push_back(rd_data);
                beat_last.push_back(rd_data_last);
            end
            if (rd_req_valid && rd_req_ready) grant_q.push_back(1'b0);
            if (wr_req_valid && wr_req_ready) grant_q.push_back(1'b1);
            if (port_busy && (mem_renable || mem_wenable)) viol++;
            if (mem_renable && mem_wenable) viol++;
            if (hold_q && (!rd_data_valid || rd_data !== hold_data)) viol++;
            hold_q    = rd_data_valid && !rd_data_ready;
            hold_data = rd_data;
        end else begin
            hold_q = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_rows.delete(); wr_rows.delete(); wr_datas.delete(); wr_bes.delete();
        beat_data.delete(); beat_last.delete(); grant_q.delete();
        wr_done_cnt = 0; wr_done_at = 0;
    endtask

    task automatic send_rd(input logic [7:0] idx, input logic [7:0] len);
        bit got;
        got = 1'b0;
        rd_req_valid = 1'b1; rd_req_index = idx; rd_req_len = len;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = rd_req_ready;
            tick();
        end
        rd_req_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rd_req_accept idx=%0h: ready never seen, required within 100 cycles", idx);
        end
    endtask

    task automatic send_wr(input logic [7:0] idx, input logic [7:0] len);
        bit got;
        got = 1'b0;
        wr_req_valid = 1'b1; wr_req_index = idx; wr_req_len = len;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = wr_req_ready;
            tick();
        end
        wr_req_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wr_req_accept idx=%0h: ready never seen, required within 100 cycles", idx);
        end
    endtask

    task automatic drive_wr(input int nbeats, input logic [7:0] k0, input logic [BW_BE-1:0] last_be);
        bit got;
        logic [7:0] k;
        k = k0;
        for (int b = 0; b < nbeats; b++) begin
            got = 1'b0;
            wr_data_valid = 1'b1;
            wr_data = wdat(k);
            wr_be = (b == nbeats - 1) ? last_be : {BW_BE{1'b1}};
            for (int n = 0; n < 100 && !got; n++) begin
                @(negedge clk);
                got = wr_data_ready;
                tick();
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL wr_data_accept beat %0d: ready never seen, required within 100 cycles", b);
            end
            k = k + 8'd1;
        end
        wr_data_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int limit);
        for (int c = 0; c < limit && beat_data.size() < n; c++) tick();
        checks++;
        if (beat_data.size() != n) begin
            errors++;
            $display("FAIL beat_count: got %0d beats, required %0d", beat_data.size(), n);
        end
    endtask

    task automatic check_beats(input string name, input logic [7:0] row0, input int n);
        logic [7:0] e;
        e = row0;
        for (int i = 0; i < n && i < beat_data.size(); i++) begin
            checks++;
            if (beat_data[i] !== pat(e) || beat_last[i] !== (i == n - 1)) begin
                errors++;
                $display("FAIL %s beat %0d: got data[31:0]=%h last=%b, required data[31:0]=%h last=%b",
                         name, i, beat_data[i][31:0], beat_last[i], pat(e) >> (WIDTH - 32), (i == n - 1));
            end
            e = e + 8'd1;
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0 || rd_data_valid !== 1'b0 ||
            rd_data_last !== 1'b0 || wr_data_ready !== 1'b0 || wr_done !== 1'b0 ||
            mem_renable !== 1'b0 || mem_wenable !== 1'b0 || mem_index !== 8'h00 ||
            mem_byte_enable !== {BW_BE{1'b0}} || rd_data !== {WIDTH{1'b0}} || mem_wdata !== {WIDTH{1'b0}}) begin
            errors++;
            $display("FAIL %s: got rrdy=%b wrdy=%b rvld=%b rlast=%b wdrdy=%b wdone=%b ren=%b wen=%b idx=%h, required all 0",
                     name, rd_req_ready, wr_req_ready, rd_data_valid, rd_data_last, wr_data_ready,
                     wr_done, mem_renable, mem_wenable, mem_index);
        end
    endtask

    task automatic test_reset();
        rstnn = 1'b0;
        rd_req_valid = 1'b1; rd_req_index = 8'h05; rd_req_len = 8'd0;
        wr_req_valid = 1'b1; wr_req_index = 8'h06; wr_req_len = 8'd0;
        wr_data = wdat(8'h00); wr_be = {BW_BE{1'b1}}; wr_data_valid = 1'b1;
        rd_data_ready = 1'b1; port_busy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_zero_outputs("reset_outputs");
        tick();
        rstnn = 1'b1;
        @(negedge clk);
        checks++;
        if (rd_req_ready !== 1'b0 || wr_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_after_reset: got rd_ready=%b wr_ready=%b, required 0 0", rd_req_ready, wr_req_ready);
        end
        tick();
        rd_req_valid = 1'b0; wr_req_valid = 1'b0; wr_data_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic_read();
        logic [7:0] e;
        clear_log();
        rd_data_ready = 1'b1;
        send_rd(8'h10, 8'd3);
        wait_beats(4, 50);
        checks++;
        if (rd_rows.size() != 4) begin
            errors++;
            $display("FAIL basic_read_issues: got %0d issues, required 4", rd_rows.size());
        end
        e = 8'h10;
        for (int i = 0; i < rd_rows.size() && i < 4; i++) begin
            checks++;
            if (rd_rows[i] !== e) begin
                errors++;
                $display("FAIL basic_read_row %0d: got %h, required %h", i, rd_rows[i], e);
            end
            e = e + 8'd1;
        end
        check_beats("basic_read", 8'h10, 4);
    endtask

    task automatic test_write_wrap();
        logic [7:0]       rows [3];
        logic [WIDTH-1:0] exp0, nd;
        rows[0] = 8'hFE; rows[1] = 8'hFF; rows[2] = 8'h00;
        clear_log();
        send_wr(8'hFE, 8'd2);
        drive_wr(3, 8'h01, {{(BW_BE-4){1'b0}}, 4'hF});
        repeat (3) tick();
        checks++;
        if (wr_rows.size() != 3 || wr_done_cnt != 1 || wr_done_at != 3) begin
            errors++;
            $display("FAIL write_wrap_done: got writes=%0d done=%0d at=%0d, required 3 1 3",
                     wr_rows.size(), wr_done_cnt, wr_done_at);
        end
        for (int i = 0; i < wr_rows.size() && i < 3; i++) begin
            checks++;
            if (wr_rows[i] !== rows[i] || wr_datas[i] !== wdat(8'(i + 1))) begin
                errors++;
                $display("FAIL write_wrap_row %0d: got row %h, required %h (or data differs)", i, wr_rows[i], rows[i]);
            end
        end
        if (wr_bes.size() == 3) begin
            checks++;
            if (wr_bes[2] !== {{(BW_BE-4){1'b0}}, 4'hF}) begin
                errors++;
                $display("FAIL write_byte_enable: got %h, required low 4 bytes", wr_bes[2]);
            end
        end
        // read row 0 back: only its low 4 bytes were replaced
        nd = wdat(8'h03);
        exp0 = pat(8'h00);
        exp0[31:0] = nd[31:0];
        clear_log();
        rd_data_ready = 1'b1;
        send_rd(8'h00, 8'd0);
        wait_beats(1, 30);
        if (beat_data.size() >= 1) begin
            checks++;
            if (beat_data[0] !== exp0 || beat_last[0] !== 1'b1) begin
                errors++;
                $display("FAIL readback_row0: got low word %h last=%b, required low word %h last=1",
                         beat_data[0][63:0], beat_last[0], exp0[63:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        rd_data_ready = 1'b0;
        send_rd(8'h20, 8'd7);
        repeat (20) tick();
        @(negedge clk);
        checks++;
        if (rd_rows.size() > 2 || rd_rows.size() == 0 || rd_data_valid !== 1'b1 || beat_data.size() != 0) begin
            errors++;
            $display("FAIL backpressure_stall: got issues=%0d valid=%b taken=%0d, required 1..2 1 0",
                     rd_rows.size(), rd_data_valid, beat_data.size());
        end
        tick();
        rd_data_ready = 1'b1;
        port_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_renable !== 1'b0) begin
                errors++;
                $display("FAIL busy_read_block cycle %0d: got mem_renable=%b, required 0", c, mem_renable);
            end
            tick();
        end
        port_busy = 1'b0;
        wait_beats(8, 100);
        check_beats("backpressure", 8'h20, 8);
        checks++;
        if (rd_rows.size() != 8) begin
            errors++;
            $display("FAIL backpressure_issues: got %0d, required 8", rd_rows.size());
        end
    endtask

    task automatic test_port_busy();
        logic [7:0] e;
        clear_log();
        send_wr(8'h40, 8'd3);
        drive_wr(1, 8'h10, {BW_BE{1'b1}});
        port_busy = 1'b1;
        wr_data_valid = 1'b1; wr_data = wdat(8'h11); wr_be = {BW_BE{1'b1}};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (wr_data_ready !== 1'b0 || mem_wenable !== 1'b0) begin
                errors++;
                $display("FAIL busy_write_block cycle %0d: got ready=%b wen=%b, required 0 0", c, wr_data_ready, mem_wenable);
            end
            tick();
        end
        port_busy = 1'b0;
        drive_wr(3, 8'h11, {BW_BE{1'b1}});
        repeat (2) tick();
        checks++;
        if (wr_rows.size() != 4 || wr_done_cnt != 1 || wr_done_at != 4) begin
            errors++;
            $display("FAIL busy_write_done: got writes=%0d done=%0d at=%0d, required 4 1 4",
                     wr_rows.size(), wr_done_cnt, wr_done_at);
        end
        e = 8'h40;
        for (int i = 0; i < wr_rows.size() && i < 4; i++) begin
            checks++;
            if (wr_rows[i] !== e || wr_datas[i] !== wdat(8'(8'h10 + i))) begin
                errors++;
                $display("FAIL busy_write_row %0d: got %h, required %h (or data differs)", i, wr_rows[i], e);
            end
            e = e + 8'd1;
        end
    endtask

    task automatic test_arbitration();
        bit exp [4];
`ifdef QGEMM_SCHED_RR_EN
        exp[0] = 1'b0; exp[1] = 1'b1; exp[2] = 1'b0; exp[3] = 1'b1;
`else
        exp[0] = 1'b0; exp[1] = 1'b0; exp[2] = 1'b0; exp[3] = 1'b0;
`endif
        rstnn = 1'b0;
        tick();
        rstnn = 1'b1;
        repeat (2) tick();
        clear_log();
        rd_data_ready = 1'b1;
        rd_req_index = 8'h50; rd_req_len = 8'd0;
        wr_req_index = 8'h60; wr_req_len = 8'd0;
        wr_data = wdat(8'h20); wr_be = {BW_BE{1'b1}}; wr_data_valid = 1'b1;
        rd_req_valid = 1'b1; wr_req_valid = 1'b1;
        for (int c = 0; c < 200 && grant_q.size() < 4; c++) tick();
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        repeat (3) tick();
        wr_data_valid = 1'b0;
        repeat (6) tick();
        checks++;
        if (grant_q.size() < 4) begin
            errors++;
            $display("FAIL arb_grant_count: got %0d grants, required 4", grant_q.size());
        end
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            checks++;
            if (grant_q[i] !== exp[i]) begin
                errors++;
                $display("FAIL arb_grant %0d: got %s, required %s", i, grant_q[i] ? "W" : "R", exp[i] ? "W" : "R");
            end
        end
    endtask

    task automatic test_reset_mid_read();
        clear_log();
        rd_data_ready = 1'b0;
        send_rd(8'h30, 8'd7);
        repeat (4) tick();
        rstnn = 1'b0;
        @(negedge clk);
        check_zero_outputs("mid_burst_reset_outputs");
        tick();
        clear_log();
        rstnn = 1'b1;
        rd_data_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        checks++;
        if (beat_data.size() != 0 || rd_rows.size() != 0 || rd_data_valid !== 1'b0 || wr_done_cnt != 0) begin
            errors++;
            $display("FAIL after_reset_quiet: got beats=%0d issues=%0d valid=%b done=%0d, required 0 0 0 0",
                     beat_data.size(), rd_rows.size(), rd_data_valid, wr_done_cnt);
        end
        tick();
        send_rd(8'h31, 8'd0);
        wait_beats(1, 30);
        repeat (4) tick();
        checks++;
        if (beat_data.size() != 1) begin
            errors++;
            $display("FAIL after_reset_beats: got %0d, required 1", beat_data.size());
        end
        check_beats("after_reset", 8'h31, 1);
    endtask

    task automatic test_invariants();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL port_invariants: got %0d violations, required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_wrap();
        test_backpressure();
        test_port_busy();
        test_arbitration();
        test_reset_mid_read();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
